// File: rtl/sm3_pkg.sv
// sm3_pkg: shared SM3 round constants, controller state encoding and rotate helper
package sm3_pkg;
  localparam logic [31:0] T0 = 32'h79CC4519;
  localparam logic [31:0] T1 = 32'h7A879D8A;
  localparam logic [31:0] T1_ROT16 = 32'h9D8A7A87;
  localparam int ROUNDS = 64;
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;
  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction
endpackage

// File: rtl/sm3_tj_gen.sv
// sm3_tj_gen: rotating Tj register producing Tj<<<(j mod 32) one round at a time
module sm3_tj_gen
  import sm3_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic        j_is_15,
  output logic [31:0] tj
);
  // T1<<<16 is reloaded entering j=16 so the rotation continues with the second constant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tj <= '0;
    else if (load) tj <= T0;
    else if (step) tj <= j_is_15 ? T1_ROT16 : rotl1(tj);
  end
endmodule

// File: rtl/sm3_round_ctrl.sv
// sm3_round_ctrl: sequences load, 64 compression rounds and the final chaining xor of one SM3 block
module sm3_round_ctrl
  import sm3_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        first,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        load_en,
  output logic        iv_sel,
  output logic        round_en,
  output logic [5:0]  round_idx,
  output logic        sel_gg,
  output logic [31:0] tj_shift_j,
  output logic        final_en,
  output logic        done
);
  state_t st, nxt;
  logic [5:0] j_q;
  logic first_q;
  logic [31:0] tj;
  logic in_round;
  assign in_round = st == ROUND;
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  end
  // round counter runs only inside ROUND and drops back to 0 after round 63 or on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) j_q <= '0;
    else j_q <= (in_round && !flush && j_q != 6'(ROUNDS - 1)) ? j_q + 6'd1 : 6'd0;
  end
  // remember whether the accepted block starts a message, for iv_sel during LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) first_q <= 1'b0;
    else if (st == IDLE && start && !flush) first_q <= first;
  end
  sm3_tj_gen u_tj (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (st == LOAD),
    .step    (in_round),
    .j_is_15 (j_q == 6'd15),
    .tj      (tj)
  );
  // next state and decoded outputs; flush overrides every transition
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = ROUND;
      ROUND:   nxt = (j_q == 6'(ROUNDS - 1)) ? FINAL : ROUND;
      FINAL:   nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (flush) nxt = IDLE;
    ready = st == IDLE;
    busy = st != IDLE;
    load_en = st == LOAD;
    iv_sel = (st == LOAD) && first_q;
    round_en = in_round;
    round_idx = j_q;
    sel_gg = in_round && j_q >= 6'd16;
    tj_shift_j = in_round ? tj : '0;
    final_en = st == FINAL;
    done = st == DONE;
  end
endmodule
